dt_map_pack: RTL
================

// Module: dt_map_pack
// PURPOSE
//  Reads a 128x128 8-bit distance map from the result RAM (res_* port, same layout as DT output).
//  Thresholds every pixel and packs 16 pixels per 16-bit word.
//  Writes the 1024-word binary image into a sti-format memory, so the map can be re-fed to DT.
//  Sits after DT in the image pipeline.
// PARAMETERS
//  INVERT   0   0: bit=(res_di>=thr); 1: bit=(res_di<thr)
//  (image geometry fixed: 128x128 pixels, 8-bit pixel, 16-bit word, 8 words per row)
// PORTS
//  clk       in   1   single clock, all logic on posedge
//  reset     in   1   asynchronous, active-low; clears all state and outputs
//  start     in   1   one-cycle pulse; begins a full-frame conversion (accepted in IDLE or DONE only)
//  thr       in   8   threshold, sampled on the cycle start is accepted
//  done      out  1   high in DONE state until next accepted start or reset
//  res_rd    out  1   result-RAM read enable
//  res_addr  out  14  pixel address {row[6:0],col[6:0]}
//  res_di    in   8   read data, valid the cycle after res_rd/res_addr (sampled at the following posedge)
//  sti_wr    out  1   packed-image write strobe, one cycle per word
//  sti_addr  out  10  word address {row[6:0],col[6:4]}
//  sti_do    out  16  packed word; pixel col[3:0]=0 in bit 15, col[3:0]=15 in bit 0
// BEHAVIOUR
//  All outputs registered. Reset values: done=0, res_rd=0, res_addr=0, sti_wr=0, sti_addr=0, sti_do=0.
//  FSM: IDLE -(start)-> RUN -(last address issued)-> FLUSH -(last word written)-> DONE -(start)-> RUN.
//  IDLE: no memory activity; waits for start; thr latched into thr_q on acceptance.
//  RUN: one read per cycle, pixel index p=0..16383 in raster order (row-major, col fastest).
//   Cycle 0 = start-accept cycle; res_rd=1, res_addr=p during cycle 1+p.
//   res_rd drops to 0 after p=16383 (cycle 16385 onward); state moves to FLUSH.
//  Data path: res_di for pixel p captured at end of cycle 2+p; threshold bit shifted into 16-bit shreg MSB-first.
//   Compare is unsigned 8-bit; thr_q=0 with INVERT=0 gives all ones; thr_q=0 with INVERT=1 gives all zeros.
//  Write: after the 16th bit of word w (w=0..1023) is captured, sti_wr=1 for exactly cycle 16w+18, with sti_addr=w, sti_do=packed word.
//   sti_wr=0 in every other cycle; sti_addr/sti_do hold their last value.
//  Reads and writes overlap freely (independent memories); no back-pressure; throughput 1 pixel/cycle.
//  FLUSH: no reads; completes capture of pixels 16368..16383 and the write of word 1023 (cycle 16386).
//  DONE: done=1 from cycle 16387; start there restarts (done=0 next cycle, first read cycle after accept).
//  Total latency start-accept to done=1: 16387 cycles.
//  start while RUN/FLUSH: ignored, thr not resampled, no effect on the frame.
//  Counters: 14-bit pixel-issue counter and 14-bit capture counter; both stop at 16383, no wrap into a second frame.
//  Border pixels (row/col 0 or 127) processed like any other; no special casing.
//  Reset mid-operation: immediate return to IDLE, outputs to reset values, partial word discarded, nothing written until a new start.
// TESTING
//  1 res all 0x00, thr=1, INVERT=0 -> 1024 writes, every sti_do=0x0000, sti_addr 0..1023 ascending, done at cycle 16387.
//  2 res[r][c]=c, thr=16 -> word addr%8==0 gives 0x0000, all others 0xFFFF; INVERT=1 swaps the two values.
//  3 res[r][c]=(c==0)?5:0, thr=5 -> every word with addr%8==0 is 0x8000 (bit order), others 0x0000.
//  4 Timing: first sti_wr at cycle 18, sti_addr=0; res_rd high for exactly 16384 consecutive cycles starting cycle 1.
//  5 start pulsed at cycle 3000 with thr changed -> ignored; output identical to run without it.
//  6 reset low at cycle 5000 -> all outputs 0 that cycle, no sti_wr until new start; rerun from DONE produces a full frame.

Source files
------------

// File: rtl/dt_map_pack_if.sv
// Memory-side bus of dt_map_pack: result-RAM read port and packed-image write port.
interface dt_map_pack_if;
   logic        res_rd;
   logic [13:0] res_addr;
   logic [7:0]  res_di;
   logic        sti_wr;
   logic [9:0]  sti_addr;
   logic [15:0] sti_do;

   modport master (
      output res_rd, res_addr, sti_wr, sti_addr, sti_do,
      input  res_di
   );

   modport slave (
      input  res_rd, res_addr, sti_wr, sti_addr, sti_do,
      output res_di
   );
endinterface

// File: rtl/dt_map_pack.sv
// Thresholds a 128x128 8-bit distance map and packs it 16 pixels per word into a
// sti-format binary image (MSB = leftmost pixel), one pixel per cycle.
module dt_map_pack #(
   parameter bit INVERT = 1'b0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [7:0]    thr,
   output logic          done,
   dt_map_pack_if.master bus
);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

   state_t      state;
   logic [7:0]  thr_q;
   logic        rd_q;
   logic [13:0] cap_cnt;
   logic [15:0] shreg;
   logic        pix_bit;

   always_comb begin
      pix_bit = INVERT ? (bus.res_di < thr_q) : (bus.res_di >= thr_q);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         done         <= 1'b0;
         thr_q        <= '0;
         rd_q         <= 1'b0;
         cap_cnt      <= '0;
         shreg        <= '0;
         bus.res_rd   <= 1'b0;
         bus.res_addr <= '0;
         bus.sti_wr   <= 1'b0;
         bus.sti_addr <= '0;
         bus.sti_do   <= '0;
      end else begin
         bus.sti_wr <= 1'b0;
         rd_q       <= bus.res_rd;

         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state        <= RUN;
                  done         <= 1'b0;
                  thr_q        <= thr;
                  cap_cnt      <= '0;
                  bus.res_rd   <= 1'b1;
                  bus.res_addr <= '0;
               end
            end
            RUN: begin
               if (bus.res_addr == '1) begin
                  bus.res_rd <= 1'b0;
                  state      <= FLUSH;
               end else begin
                  bus.res_addr <= bus.res_addr + 14'd1;
               end
            end
            FLUSH: begin
               // the final word's strobe is on the bus this cycle
               if (bus.sti_wr && bus.sti_addr == '1) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase

         // read data lands one cycle behind the issued address
         if (rd_q) begin
            shreg <= {shreg[14:0], pix_bit};
            if (cap_cnt[3:0] == 4'hF) begin
               bus.sti_wr   <= 1'b1;
               bus.sti_addr <= cap_cnt[13:4];
               bus.sti_do   <= {shreg[14:0], pix_bit};
            end
            if (cap_cnt != '1) begin
               cap_cnt <= cap_cnt + 14'd1;
            end
         end
      end
   end

endmodule
